// File: rtl/seq_divider.sv
// Iterative signed divider: one restoring-division step per cycle on operand magnitudes,
// followed by a sign-correction/flag stage. Fixed latency for every operand pair.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             ovf,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = ~MIN_NEG;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;

    logic [WIDTH-1:0] r_a;      // original dividend, returned as remainder on b=0
    logic [WIDTH-1:0] r_div;    // |b|
    logic [WIDTH-1:0] r_dq;     // |a| shifting out, quotient bits shifting in
    logic [WIDTH:0]   r_prem;   // partial remainder
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic             r_ov;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_next_prem;
    logic             w_load;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_if(input logic [WIDTH-1:0] m, input logic neg);
        return neg ? (~m + WIDTH'(1)) : m;
    endfunction

    // Saturation and divide-by-zero substitution for the quotient.
    function automatic logic [WIDTH-1:0] fix_quot(input logic [WIDTH-1:0] m, input logic neg,
                                                  input logic dz, input logic ov);
        if (dz) return '0;
        if (ov) return MAX_POS;
        return negate_if(m, neg);
    endfunction

    function automatic logic [WIDTH-1:0] fix_rem(input logic [WIDTH-1:0] m, input logic neg,
                                                 input logic dz, input logic [WIDTH-1:0] dividend);
        if (dz) return dividend;
        return negate_if(m, neg);
    endfunction

    // Restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    assign w_shift     = {r_prem[WIDTH-1:0], r_dq[WIDTH-1]};
    assign w_diff      = {1'b0, w_shift} - {2'b00, r_div};
    assign w_ge        = ~w_diff[WIDTH+1] | r_prem[WIDTH];
    assign w_next_prem = w_ge ? w_diff[WIDTH:0] : w_shift;
    assign w_load      = (r_state == S_IDLE) && start;

    // Datapath registers: no reset, only loaded on accept and stepped in CALC.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_a     <= a;
            r_div   <= mag(b);
            r_dq    <= mag(a);
            r_prem  <= '0;
            r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            r_neg_r <= a[WIDTH-1];
            r_dz    <= (b == '0);
            r_ov    <= (a == MIN_NEG) && (b == '1);
        end else if (r_state == S_CALC) begin
            r_prem  <= w_next_prem;
            r_dq    <= {r_dq[WIDTH-2:0], w_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_cnt   <= CW'(WIDTH - 1);
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    quot     <= fix_quot(r_dq, r_neg_q, r_dz, r_ov);
                    rem      <= fix_rem(r_prem[WIDTH-1:0], r_neg_r, r_dz, r_a);
                    ovf      <= r_ov;
                    div_zero <= r_dz;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, handshake/reset sequences and a random sweep
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int W   = 8;
    localparam int LAT = W + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic signed [W-1:0] a, b;
    logic                busy, done;
    logic signed [W-1:0] quot, rem;
    logic                ovf, div_zero;

    int nchecks = 0;
    int nerrors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .quot(quot), .rem(rem),
        .ovf(ovf), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [W-1:0] q;
        logic signed [W-1:0] r;
        logic                o;
        logic                z;
    } res_t;

    typedef struct {
        int a; int b; int q; int r; int o; int z;
    } vec_t;

    task automatic chk(input string nm, input int got, input int exp);
        nchecks++;
        if (got != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Reference: plain integer division, which truncates toward zero.
    function automatic res_t model(input int x, input int y);
        res_t m;
        m.o = 1'b0;
        m.z = 1'b0;
        if (y == 0) begin
            m.q = '0; m.r = W'(x); m.z = 1'b1;
        end else if (x == -(1 << (W-1)) && y == -1) begin
            m.q = W'((1 << (W-1)) - 1); m.r = '0; m.o = 1'b1;
        end else begin
            m.q = W'(x / y); m.r = W'(x % y);
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done is seen (bounded); also counts busy cycles on the way.
    task automatic wait_done(output int lat, output int bcyc);
        lat = 0;
        bcyc = 0;
        while (!done && lat < 40) begin
            if (busy) bcyc++;
            step();
            lat++;
        end
    endtask

    task automatic run_div(input int ta, input int tb_, output res_t got,
                           output int lat, output int bcyc);
        a = W'(ta);
        b = W'(tb_);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bcyc);
        got.q = quot; got.r = rem; got.o = ovf; got.z = div_zero;
    endtask

    initial begin
        vec_t vecs[$];
        res_t got, exp;
        int lat, bcyc, ndone;
        int ra, rb;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_quot", int'(quot), 0);
        chk("reset_rem", int'(rem), 0);
        chk("reset_flags", int'({ovf, div_zero}), 0);

        vecs.push_back('{7, 2, 3, 1, 0, 0});
        vecs.push_back('{-7, 2, -3, -1, 0, 0});
        vecs.push_back('{7, -2, -3, 1, 0, 0});
        vecs.push_back('{-7, -2, 3, -1, 0, 0});
        vecs.push_back('{-128, -1, 127, 0, 1, 0});
        vecs.push_back('{-128, 1, -128, 0, 0, 0});
        vecs.push_back('{0, -5, 0, 0, 0, 0});
        vecs.push_back('{42, 0, 0, 42, 0, 1});
        vecs.push_back('{42, 5, 8, 2, 0, 0});
        vecs.push_back('{100, 7, 14, 2, 0, 0});
        vecs.push_back('{127, -128, 0, 127, 0, 0});
        vecs.push_back('{-128, -128, 1, 0, 0, 0});
        vecs.push_back('{-1, 127, 0, -1, 0, 0});
        vecs.push_back('{-128, 0, 0, -128, 0, 1});

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, got, lat, bcyc);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            if (i == 0) chk("vec0_busy_cycles", bcyc, LAT);
            chk($sformatf("vec%0d_quot", i), int'(got.q), vecs[i].q);
            chk($sformatf("vec%0d_rem", i), int'(got.r), vecs[i].r);
            chk($sformatf("vec%0d_ovf", i), int'(got.o), vecs[i].o);
            chk($sformatf("vec%0d_divzero", i), int'(got.z), vecs[i].z);
            chk($sformatf("vec%0d_done_width", i), int'(done), 1);
            step();
            chk($sformatf("vec%0d_done_drop", i), int'(done), 0);
        end

        // start re-pulsed and operands changed mid-CALC must not disturb 100/7.
        a = 8'sd100; b = 8'sd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        a = 8'sd9; b = 8'sd3; start = 1'b1;
        step();
        start = 1'b0; a = -8'sd50; b = 8'sd0;
        wait_done(lat, bcyc);
        chk("ignore_start_latency", lat + 4, LAT);
        chk("ignore_start_quot", int'(quot), 14);
        chk("ignore_start_rem", int'(rem), 2);

        // start on the done cycle launches the next division immediately.
        a = 8'sd9; b = 8'sd3; start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_busy", int'(busy), 1);
        wait_done(lat, bcyc);
        chk("b2b_latency", lat, LAT);
        chk("b2b_quot", int'(quot), 3);
        chk("b2b_rem", int'(rem), 0);

        // Reset in the fourth CALC cycle aborts with no done pulse.
        step();
        a = 8'sd100; b = 8'sd7; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_quot", int'(quot), 0);
        chk("abort_rem", int'(rem), 0);
        chk("abort_flags", int'({ovf, div_zero}), 0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            if (done || busy) ndone++;
            step();
        end
        chk("abort_no_activity", ndone, 0);
        run_div(-9, 2, got, lat, bcyc);
        chk("after_abort_latency", lat, LAT);
        chk("after_abort_quot", int'(got.q), -4);
        chk("after_abort_rem", int'(got.r), -1);

        // Random sweep against the reference model, biased toward the corner operands.
        for (int i = 0; i < 3000; i++) begin
            ra = $signed(W'($urandom));
            rb = $signed(W'($urandom));
            case ($urandom_range(0, 15))
                0: rb = 0;
                1: begin ra = -128; rb = -1; end
                2: ra = -128;
                3: rb = -128;
                default: ;
            endcase
            exp = model(ra, rb);
            run_div(ra, rb, got, lat, bcyc);
            nchecks++;
            if (lat != LAT || got.q != exp.q || got.r != exp.r || got.o != exp.o || got.z != exp.z) begin
                nerrors++;
                $display("FAIL rand %0d/%0d: got q=%0d r=%0d ovf=%0d dz=%0d lat=%0d expected q=%0d r=%0d ovf=%0d dz=%0d lat=%0d",
                         ra, rb, got.q, got.r, got.o, got.z, lat, exp.q, exp.r, exp.o, exp.z, LAT);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
